// File: rtl/fft_harmonic_extractor_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_harmonic_extractor_if
// Brief    : Spectrum input stream and harmonic result bus of the extractor.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_harmonic_extractor_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] in_data;
    logic              in_sop;
    logic              in_eop;
    logic              busy;
    logic [ADDR_W-1:0] fund_bin;
    logic              harm_valid;
    logic [2:0]        harm_k;
    logic [ADDR_W+2:0] harm_bin;
    logic [DATA_W-1:0] harm_power;
    logic              harm_oob;
    logic              frame_done;
    logic              frame_err;

    modport master (
        output in_data, in_sop, in_eop,
        input  busy, fund_bin, harm_valid, harm_k, harm_bin, harm_power,
               harm_oob, frame_done, frame_err
    );

    modport slave (
        input  in_data, in_sop, in_eop,
        output busy, fund_bin, harm_valid, harm_k, harm_bin, harm_power,
               harm_oob, frame_done, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/fft_harmonic_extractor.sv
`default_nettype none
// ============================================================================
// Module   : fft_harmonic_extractor
// Brief    : Buffers one power spectrum frame, finds the fundamental bin and
//            streams out the power at harmonics 1..NUM_HARM.
// Revision : 1.0 - initial release
// ============================================================================
module fft_harmonic_extractor #(
    parameter int N_POINTS = 1024,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 24,
    parameter int NUM_HARM = 5,
    parameter int DC_SKIP  = 2
) (
    input wire clk,
    input wire rst_n,
    fft_harmonic_extractor_if.slave bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_HARM    = 2'd2;

    localparam logic [ADDR_W-1:0] c_last_bin = ADDR_W'(N_POINTS - 1);
    localparam logic [ADDR_W-1:0] c_half     = ADDR_W'(N_POINTS / 2);
    localparam logic [ADDR_W-1:0] c_dc_skip  = ADDR_W'(DC_SKIP);
    localparam logic [ADDR_W+2:0] c_half_acc = (ADDR_W+3)'(N_POINTS / 2);
    localparam logic [2:0]        c_last_k   = 3'(NUM_HARM);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    logic              w_sop_accept;
    logic              w_wr_en;
    logic              w_err;
    logic              w_harm_start;
    logic              w_busy;

    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_above_dc;
    logic              w_in_search;
    logic [DATA_W-1:0] w_peak_base;
    logic [DATA_W-1:0] r_peak_val;
    logic [ADDR_W-1:0] r_peak_idx;

    logic [DATA_W-1:0] r_mem [0:N_POINTS-1];
    logic [DATA_W-1:0] r_rd_data;
    logic              w_rd_en;

    logic [ADDR_W-1:0] r_fund_bin;
    logic [ADDR_W+2:0] r_acc;
    logic [2:0]        r_step;
    logic              r_issue;
    logic              w_acc_oob;

    logic              r_s1_valid;
    logic [2:0]        r_s1_k;
    logic [ADDR_W+2:0] r_s1_bin;
    logic              r_s1_oob;

    logic              r_harm_valid;
    logic [2:0]        r_harm_k;
    logic [ADDR_W+2:0] r_harm_bin;
    logic [DATA_W-1:0] r_harm_power;
    logic              r_harm_oob;
    logic              r_frame_done;
    logic              r_frame_err;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_sop) w_next_state = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (bus.in_sop)
                    w_next_state = S_CAPTURE;
                else if (bus.in_eop)
                    w_next_state = (r_cnt == c_last_bin) ? S_HARM : S_IDLE;
                else if (r_cnt == c_last_bin)
                    w_next_state = S_IDLE;
            end
            S_HARM: begin
                if (r_frame_done) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // sop during HARM is deliberately not accepted: that frame is dropped.
    always_comb begin
        w_sop_accept = 1'b0;
        w_wr_en      = 1'b0;
        w_err        = 1'b0;
        w_harm_start = 1'b0;
        w_busy       = (r_state != S_IDLE);
        if (r_state == S_IDLE || r_state == S_CAPTURE)
            w_sop_accept = bus.in_sop;
        if (r_state == S_CAPTURE) begin
            w_wr_en      = 1'b1;
            w_err        = bus.in_sop ||
                           (bus.in_eop ? (r_cnt != c_last_bin) : (r_cnt == c_last_bin));
            w_harm_start = !bus.in_sop && bus.in_eop && (r_cnt == c_last_bin);
        end else if (w_sop_accept) begin
            w_wr_en = 1'b1;
        end
    end

    // ------------------------------------------------------ capture and peak
    assign w_wr_addr   = w_sop_accept ? '0 : r_cnt;
    assign w_in_search = w_above_dc && (w_wr_addr < c_half);
    assign w_peak_base = w_sop_accept ? '0 : r_peak_val;

    generate
        if (DC_SKIP == 0) begin : g_dc_none
            assign w_above_dc = 1'b1;
        end else begin : g_dc_skip
            assign w_above_dc = (w_wr_addr >= c_dc_skip);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_peak_val <= '0;
            r_peak_idx <= '0;
        end else begin
            if (w_sop_accept)
                r_cnt <= ADDR_W'(1);
            else if (r_state == S_CAPTURE)
                r_cnt <= r_cnt + ADDR_W'(1);

            // Strict compare keeps the lowest bin on ties; seed makes an all-zero search land on DC_SKIP.
            if (w_wr_en && w_in_search && (bus.in_data > w_peak_base)) begin
                r_peak_val <= bus.in_data;
                r_peak_idx <= w_wr_addr;
            end else if (w_sop_accept) begin
                r_peak_val <= '0;
                r_peak_idx <= c_dc_skip;
            end
        end
    end

    // Frame buffer: plain synchronous RAM, one write and one registered read port.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[w_wr_addr] <= bus.in_data;
        if (w_rd_en) r_rd_data <= r_mem[r_acc[ADDR_W-1:0]];
    end

    // ---------------------------------------------------- harmonic sequencer
    assign w_acc_oob = (r_acc >= c_half_acc);
    assign w_rd_en   = r_issue && !w_acc_oob;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fund_bin <= '0;
            r_acc      <= '0;
            r_step     <= '0;
            r_issue    <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_k     <= '0;
            r_s1_bin   <= '0;
            r_s1_oob   <= 1'b0;
        end else begin
            if (w_harm_start) begin
                r_fund_bin <= r_peak_idx;
                r_acc      <= {3'b000, r_peak_idx};
                r_step     <= 3'd1;
                r_issue    <= 1'b1;
            end else if (r_issue) begin
                r_acc  <= r_acc + {3'b000, r_fund_bin};
                r_step <= r_step + 3'd1;
                if (r_step == c_last_k) r_issue <= 1'b0;
            end
            r_s1_valid <= r_issue;
            if (r_issue) begin
                r_s1_k   <= r_step;
                r_s1_bin <= r_acc;
                r_s1_oob <= w_acc_oob;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_harm_valid <= 1'b0;
            r_harm_k     <= '0;
            r_harm_bin   <= '0;
            r_harm_power <= '0;
            r_harm_oob   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_harm_valid <= r_s1_valid;
            r_frame_done <= r_s1_valid && (r_s1_k == c_last_k);
            r_frame_err  <= w_err;
            if (r_s1_valid) begin
                r_harm_k     <= r_s1_k;
                r_harm_bin   <= r_s1_bin;
                r_harm_oob   <= r_s1_oob;
                r_harm_power <= r_s1_oob ? '0 : r_rd_data;
            end
        end
    end

    assign bus.busy       = w_busy;
    assign bus.fund_bin   = r_fund_bin;
    assign bus.harm_valid = r_harm_valid;
    assign bus.harm_k     = r_harm_k;
    assign bus.harm_bin   = r_harm_bin;
    assign bus.harm_power = r_harm_power;
    assign bus.harm_oob   = r_harm_oob;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_harmonic_extractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_harmonic_extractor
// Brief    : Directed and random frames against a spectrum-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_harmonic_extractor;

    localparam int N    = 64;
    localparam int AW   = 6;
    localparam int DW   = 24;
    localparam int NH   = 5;
    localparam int DCS  = 2;
    localparam int HALF = N / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_harmonic_extractor_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fft_harmonic_extractor #(
        .N_POINTS(N), .ADDR_W(AW), .DATA_W(DW), .NUM_HARM(NH), .DC_SKIP(DCS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] frame [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: highest power among bins DCS..HALF-1, lowest index on ties, DCS if all zero.
    function automatic int ref_fund();
        int best = DCS;
        logic [DW-1:0] bv = '0;
        for (int b = DCS; b < HALF; b++)
            if (frame[b] > bv) begin
                bv   = frame[b];
                best = b;
            end
        return best;
    endfunction

    task automatic idle_inputs();
        bus.in_data = '0;
        bus.in_sop  = 1'b0;
        bus.in_eop  = 1'b0;
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic s, input logic e);
        bus.in_data = d;
        bus.in_sop  = s;
        bus.in_eop  = e;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input bit eop_on_sop);
        for (int b = 0; b < N; b++)
            drive(frame[b], b == 0, (b == N - 1) || (eop_on_sop && b == 0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_fund"},  bus.fund_bin, 0);
        chk({tag, "_valid"}, bus.harm_valid, 0);
        chk({tag, "_k"},     bus.harm_k, 0);
        chk({tag, "_bin"},   bus.harm_bin, 0);
        chk({tag, "_power"}, bus.harm_power, 0);
        chk({tag, "_oob"},   bus.harm_oob, 0);
        chk({tag, "_done"},  bus.frame_done, 0);
        chk({tag, "_err"},   bus.frame_err, 0);
    endtask

    // Called in cycle T+1 (eop was in cycle T); walks cycles T+1..T+NH+3.
    task automatic check_harm(input bit inject_sop, input bit reset_at_k2);
        int f = ref_fund();
        for (int c = 1; c <= NH + 3; c++) begin
            int  k   = c - 2;
            bit  vld = (c >= 3) && (c <= NH + 2);
            idle_inputs();
            if (inject_sop && c == 2) begin
                bus.in_sop  = 1'b1;
                bus.in_data = 24'h123456;
            end
            if (reset_at_k2 && c == 4) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("rst_mid_harm");
                break;
            end
            chk("harm_valid", bus.harm_valid, vld);
            chk("frame_done", bus.frame_done, c == NH + 2);
            chk("busy", bus.busy, c <= NH + 2);
            chk("fund_bin", bus.fund_bin, f);
            chk("frame_err", bus.frame_err, 0);
            if (vld) begin
                int bin = k * f;
                bit oob = (bin >= HALF);
                chk("harm_k", bus.harm_k, k);
                chk("harm_bin", bus.harm_bin, bin);
                chk("harm_oob", bus.harm_oob, oob);
                chk("harm_power", bus.harm_power, oob ? 0 : frame[bin]);
            end
            if (c == NH + 3) chk("harm_k_hold", bus.harm_k, NH);
            @(posedge clk); #1;
        end
    endtask

    task automatic fill_const(input logic [DW-1:0] v);
        for (int b = 0; b < N; b++) frame[b] = v;
    endtask

    task automatic fill_rand(input int unsigned maxv);
        for (int b = 0; b < N; b++) frame[b] = DW'($urandom_range(0, maxv));
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean frame with a descending harmonic series at bin 5
        fill_const(24'd1);
        frame[5] = 24'd1000; frame[10] = 24'd200; frame[15] = 24'd50;
        frame[20] = 24'd30;  frame[25] = 24'd10;
        send_frame(1'b0);
        check_harm(1'b0, 1'b0);
        chk("clean_fund", bus.fund_bin, 5);

        // Harmonics 3..5 fall beyond the half-spectrum
        fill_const(24'd1);
        frame[12] = 24'd9999;
        send_frame(1'b0);
        check_harm(1'b0, 1'b0);
        chk("oob_last_bin", bus.harm_bin, 60);
        chk("oob_last_flag", bus.harm_oob, 1);

        // Huge DC bins are excluded; tie between 7 and 9 resolves to 7
        fill_rand(400);
        frame[0] = 24'hFFFFFF; frame[1] = 24'hFFFFFF;
        frame[7] = 24'd500;    frame[9] = 24'd500;
        send_frame(1'b0);
        check_harm(1'b0, 1'b0);
        chk("tie_fund", bus.fund_bin, 7);

        // Short frame: eop at bin 40
        fill_rand(24'hFFFFFF);
        for (int b = 0; b <= 40; b++) drive(frame[b], b == 0, b == 40);
        idle_inputs();
        chk("short_err", bus.frame_err, 1);
        chk("short_busy", bus.busy, 0);
        chk("short_valid", bus.harm_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("short_err_clr", bus.frame_err, 0);
            chk("short_no_valid", bus.harm_valid, 0);
            chk("short_idle", bus.busy, 0);
        end
        fill_rand(24'hFFFFFF);
        send_frame(1'b0);
        check_harm(1'b0, 1'b0);

        // Restart: sop re-asserted at bin 30, new frame peaks at bin 3
        fill_rand(24'hFFFFFF);
        for (int b = 0; b < 30; b++) drive(frame[b], b == 0, 1'b0);
        fill_rand(100);
        frame[3] = 24'd5000;
        drive(frame[0], 1'b1, 1'b0);
        chk("restart_err", bus.frame_err, 1);
        chk("restart_busy", bus.busy, 1);
        drive(frame[1], 1'b0, 1'b0);
        chk("restart_err_clr", bus.frame_err, 0);
        for (int b = 2; b < N; b++) drive(frame[b], 1'b0, b == N - 1);
        check_harm(1'b0, 1'b0);
        chk("restart_fund", bus.fund_bin, 3);

        // sop during HARM is dropped without error
        fill_rand(24'hFFFFFF);
        send_frame(1'b0);
        check_harm(1'b1, 1'b0);

        // Random frames: wide values, narrow values (ties), all zero, sop+eop together
        fill_rand(24'hFFFFFF);
        send_frame(1'b0);
        check_harm(1'b0, 1'b0);
        fill_rand(7);
        send_frame(1'b0);
        check_harm(1'b0, 1'b0);
        fill_const(24'd0);
        send_frame(1'b0);
        check_harm(1'b0, 1'b0);
        chk("zero_fund", bus.fund_bin, DCS);
        fill_rand(24'hFFFFFF);
        send_frame(1'b1);
        check_harm(1'b0, 1'b0);

        // Async reset at the k=2 output aborts everything
        fill_rand(24'hFFFFFF);
        send_frame(1'b0);
        check_harm(1'b0, 1'b1);
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("post_rst_done", bus.frame_done, 0);
            chk("post_rst_valid", bus.harm_valid, 0);
            chk("post_rst_busy", bus.busy, 0);
        end

        // Recovery after reset
        fill_rand(24'hFFFFFF);
        send_frame(1'b0);
        check_harm(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_harmonic_extractor.md
Name: fft_harmonic_extractor

Overview:
- Consumes the magnitude-squared spectrum stream produced by the FFT controller: 24-bit power per bin, framed by sop/eop pulses, one bin per clock.
- Buffers one frame in on-chip RAM and finds the fundamental, the peak bin in the first half-spectrum excluding the DC bins.
- Reads back the power at the fundamental and at harmonics 2..NUM_HARM, then presents them serially to the THD/distortion computation stage.

Parameters:
- N_POINTS, 1024, FFT length; bins per frame; power of two.
- ADDR_W, 10, log2(N_POINTS).
- DATA_W, 24, width of a power sample.
- NUM_HARM, 5, harmonics reported, including the fundamental (k=1..NUM_HARM); 1..7.
- DC_SKIP, 2, bins 0..DC_SKIP-1 are excluded from the peak search.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- in_data, in, DATA_W, bin power; valid every cycle from the in_sop cycle to the in_eop cycle, inclusive.
- in_sop, in, 1, marks bin 0 of a frame.
- in_eop, in, 1, marks the last bin of a frame.
- busy, out, 1, high from an accepted sop until frame_done or an error.
- fund_bin, out, ADDR_W, bin index of the fundamental; held until the next frame_done.
- harm_valid, out, 1, one-cycle qualifier for the harm_* outputs.
- harm_k, out, 3, harmonic number 1..NUM_HARM.
- harm_bin, out, ADDR_W+3, bin index computed as k*fund_bin.
- harm_power, out, DATA_W, stored power at harm_bin; 0 if the bin is out of range.
- harm_oob, out, 1, set when harm_bin >= N_POINTS/2.
- frame_done, out, 1, one-cycle pulse coincident with the last harm_valid.
- frame_err, out, 1, one-cycle pulse when a frame is malformed.

Behaviour:
- Reset: all outputs 0; state IDLE; internal bin counter, peak value, peak index and harmonic accumulator all 0. RAM contents are don't-care.
- IDLE: wait for in_sop. On in_sop, write in_data to address 0, set bin counter to 1, seed peak value to 0, go to CAPTURE, raise busy.
- CAPTURE: each cycle, write in_data to address = bin counter, then increment the counter.
- Peak search runs on writes to bins DC_SKIP..N_POINTS/2-1, using strict greater-than. On ties, the lowest bin wins. If all considered bins are 0, fund_bin = DC_SKIP.
- The sop-cycle sample (bin 0) also takes part in the peak search if DC_SKIP = 0.
- Normal end of frame: in_eop arrives with the bin index equal to N_POINTS-1. Go to HARM and latch fund_bin.
- Error cases, each pulsing frame_err, discarding the frame, dropping busy and returning to IDLE on the next cycle:
  - in_eop arrives at any other bin index.
  - The counter passes N_POINTS-1 without in_eop.
- in_sop during CAPTURE: pulse frame_err, restart the capture at bin 0 using that cycle's data, and stay in CAPTURE.
- Simultaneous in_sop and in_eop: treat as a sop. The eop is ignored.
- HARM: the accumulator starts at fund_bin and adds fund_bin once per step (k = 1..NUM_HARM), ADDR_W+3 bits wide, with no wrap.
  - If the accumulator is below N_POINTS/2, issue a RAM read. Otherwise suppress the read; harm_power = 0 and harm_oob = 1.
  - The RAM has 1-cycle read latency. harm_* outputs are registered.
- Timing (in_eop in cycle T):
  - k=1 is output in cycle T+3.
  - Harmonic k is output in cycle T+2+k; outputs are back-to-back.
  - frame_done pulses at T+2+NUM_HARM.
  - busy falls in the cycle after frame_done.
- harm_k, harm_bin, harm_power and harm_oob hold their last values while harm_valid is low.
- in_sop while in HARM is ignored: that frame is dropped silently. No frame_err; capture re-arms only at the next sop seen in IDLE.
- Async reset mid-frame or mid-HARM aborts immediately. No frame_done and no frame_err are produced.

Test Plan:
- Clean frame (N_POINTS=64, NUM_HARM=5, DC_SKIP=2): bin 5=1000, bin 10=200, bin 15=50, bin 20=30, bin 25=10, all others 1 → fund_bin=5; harm_power 1000,200,50,30,10 at k=1..5 in cycles T+3..T+7; frame_done at T+7.
- Out-of-range harmonics: peak at bin 12 (N=64) → k=1,2 valid (bins 12,24); k=3..5 give harm_bin 36,48,60 with harm_oob=1 and harm_power=0.
- DC and ties: bins 0,1=0xFFFFFF, bins 7 and 9 both 500 → fund_bin=7.
- Short frame: in_eop at bin 40 → frame_err pulse, no harm_valid, busy low the next cycle. A following good frame is processed normally.
- Restart: in_sop re-asserted at bin 30 of CAPTURE → frame_err pulse. The new frame (peak at bin 3) completes with fund_bin=3.
- Drop and reset: in_sop during HARM → ignored, current results still complete. rst_n low at HARM k=2 → all outputs 0 immediately, no frame_done.
